prog_loader_mc: RTL and testbench

// - Parametrised UART boot/program loader: parses framed byte stream from uart_rx_prog, writes words into one of NUM_TGT memories (ICCM/DCCM DFFRAMs).
// - Successor to the single-target iccm_controller: generic word/address width, target select, checksum, timeout, explicit run/halt control of core reset.
// - Sits between uart_rx_prog and the RAM muxes in the top wrapper; core_rst_o holds the core in reset while loading.

---
 rtl/prog_loader_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_prog_loader_mc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_mc.sv
// prog_loader_mc: UART boot/program loader.
// Parses framed byte streams from the UART receiver and turns them into word
// writes to one of NUM_TGT memories, plus run/halt control of the core reset.
// Frame: 0xA5, CMD, [LEN, ADDR x AB, DATA x (LEN+1)*WB], CSUM
// CMD[7:4] selects the target memory, CMD[1:0] selects the operation
// (0 write, 1 run, 2 halt, 3 illegal). The checksum covers CMD..CSUM.

module prog_loader_mc #(
    parameter int DW      = 32,
    parameter int AW      = 14,
    parameter int NUM_TGT = 2,
    parameter int TIMEOUT = 65535,
    localparam int TW     = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          err_clr_i,
    output logic          we_o,
    output logic [TW-1:0] tgt_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic [2:0]    err_o
);

    localparam int WB  = DW / 8;
    localparam int AB  = (AW + 7) / 8;
    localparam int ABW = AB * 8;
    localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [7:0]     SYNC_BYTE = 8'hA5;
    localparam logic [7:0]     WB_LAST   = 8'(WB - 1);
    localparam logic [7:0]     AB_LAST   = 8'(AB - 1);
    localparam logic [TMW-1:0] TMO_LAST  = TMW'(TIMEOUT - 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_HALT  = 2'd2;
    localparam logic [1:0] OP_BAD   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_ADDR,
        ST_DATA,
        ST_CSUM
    } state_t;

    // Parser state
    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [TW-1:0]   tgt_q, tgt_d;
    logic            bad_q, bad_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      addr_cnt_q, addr_cnt_d;
    logic [ABW-1:0]  addr_acc_q, addr_acc_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      word_cnt_q, word_cnt_d;
    logic [DW-1:0]   data_acc_q, data_acc_d;
    logic [7:0]      sum_q, sum_d;
    logic [TMW-1:0]  tmo_q, tmo_d;

    // Registered outputs
    logic            we_q, we_d;
    logic [TW-1:0]   tgt_out_q, tgt_out_d;
    logic [AW-1:0]   addr_out_q, addr_out_d;
    logic [DW-1:0]   wdata_out_q, wdata_out_d;
    logic            core_rst_q, core_rst_d;
    logic [2:0]      err_q, err_d;

    // Combinational helpers
    logic [7:0]      sum_next;
    logic [DW-1:0]   word_next;
    logic [ABW-1:0]  addr_next;
    logic [2:0]      err_new;
    logic            busy;

    assign busy = (state_q != ST_IDLE);

    // Next-state, field assembly, write strobe, run/halt and error logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tgt_d       = tgt_q;
        bad_d       = bad_q;
        len_d       = len_q;
        addr_cnt_d  = addr_cnt_q;
        addr_acc_d  = addr_acc_q;
        waddr_d     = waddr_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        data_acc_d  = data_acc_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        we_d        = 1'b0;
        tgt_out_d   = tgt_out_q;
        addr_out_d  = addr_out_q;
        wdata_out_d = wdata_out_q;
        core_rst_d  = core_rst_q;
        err_new     = 3'b000;

        sum_next  = sum_q + rx_byte_i;
        word_next = (DW'(rx_byte_i) << (DW - 8)) | (data_acc_q >> 8);
        addr_next = (ABW'(rx_byte_i) << (ABW - 8)) | (addr_acc_q >> 8);

        if (rx_dv_i) begin
            tmo_d = '0;
            if (state_q != ST_IDLE) begin
                sum_d = sum_next;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte_i == SYNC_BYTE) begin
                        state_d = ST_CMD;
                        sum_d   = 8'h00;
                    end
                end
                ST_CMD: begin
                    op_d  = rx_byte_i[1:0];
                    tgt_d = TW'(rx_byte_i[7:4]);
                    bad_d = (32'(rx_byte_i[7:4]) >= 32'(NUM_TGT)) ||
                            (rx_byte_i[1:0] == OP_BAD);
                    if (bad_d) begin
                        err_new[2] = 1'b1;
                    end
                    if (rx_byte_i[1:0] == OP_WRITE) begin
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_CSUM;
                    end
                end
                ST_LEN: begin
                    len_d      = rx_byte_i;
                    addr_cnt_d = 8'd0;
                    state_d    = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_acc_d = addr_next;
                    if (addr_cnt_q == AB_LAST) begin
                        waddr_d    = addr_next[AW-1:0];
                        byte_cnt_d = 8'd0;
                        word_cnt_d = 8'd0;
                        state_d    = ST_DATA;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 8'd1;
                    end
                end
                ST_DATA: begin
                    data_acc_d = word_next;
                    if (byte_cnt_q == WB_LAST) begin
                        byte_cnt_d = 8'd0;
                        if (!bad_q) begin
                            we_d        = 1'b1;
                            tgt_out_d   = tgt_q;
                            addr_out_d  = waddr_q;
                            wdata_out_d = word_next;
                        end
                        waddr_d = waddr_q + AW'(1);
                        if (word_cnt_q == len_q) begin
                            state_d = ST_CSUM;
                        end else begin
                            word_cnt_d = word_cnt_q + 8'd1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (sum_next != 8'h00) begin
                        err_new[0] = 1'b1;
                    end else if (!bad_q) begin
                        if (op_q == OP_RUN) begin
                            core_rst_d = 1'b0;
                        end else if (op_q == OP_HALT) begin
                            core_rst_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (busy) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d      = '0;
                state_d    = ST_IDLE;
                byte_cnt_d = 8'd0;
                err_new[1] = 1'b1;
            end else begin
                tmo_d = tmo_q + TMW'(1);
            end
        end else begin
            tmo_d = '0;
        end

        err_d = (err_clr_i ? 3'b000 : err_q) | err_new;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            tgt_q       <= '0;
            bad_q       <= 1'b0;
            len_q       <= 8'd0;
            addr_cnt_q  <= 8'd0;
            addr_acc_q  <= '0;
            waddr_q     <= '0;
            byte_cnt_q  <= 8'd0;
            word_cnt_q  <= 8'd0;
            data_acc_q  <= '0;
            sum_q       <= 8'd0;
            tmo_q       <= '0;
            we_q        <= 1'b0;
            tgt_out_q   <= '0;
            addr_out_q  <= '0;
            wdata_out_q <= '0;
            core_rst_q  <= 1'b1;
            err_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tgt_q       <= tgt_d;
            bad_q       <= bad_d;
            len_q       <= len_d;
            addr_cnt_q  <= addr_cnt_d;
            addr_acc_q  <= addr_acc_d;
            waddr_q     <= waddr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            data_acc_q  <= data_acc_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            tgt_out_q   <= tgt_out_d;
            addr_out_q  <= addr_out_d;
            wdata_out_q <= wdata_out_d;
            core_rst_q  <= core_rst_d;
            err_q       <= err_d;
        end
    end

    assign we_o       = we_q;
    assign tgt_o      = tgt_out_q;
    assign addr_o     = addr_out_q;
    assign wdata_o    = wdata_out_q;
    assign core_rst_o = core_rst_q;
    assign busy_o     = busy;
    assign err_o      = err_q;

endmodule

// File: tb/tb_prog_loader_mc.sv
// tb_prog_loader_mc: drives framed byte streams into prog_loader_mc and
// compares writes, core reset, busy and error flags against a frame-level model.

module tb_prog_loader_mc;

    localparam int DW      = 32;
    localparam int AW      = 14;
    localparam int NUM_TGT = 2;
    localparam int TIMEOUT = 64;
    localparam int TW      = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          err_clr;
    logic          we_o;
    logic [TW-1:0] tgt_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          core_rst_o;
    logic          busy_o;
    logic [2:0]    err_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]  frame_q[$];
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic        model_core_rst;
    logic [2:0]  model_err;

    prog_loader_mc #(
        .DW(DW), .AW(AW), .NUM_TGT(NUM_TGT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx_dv_i(rx_dv),
        .rx_byte_i(rx_byte),
        .err_clr_i(err_clr),
        .we_o(we_o),
        .tgt_o(tgt_o),
        .addr_o(addr_o),
        .wdata_o(wdata_o),
        .core_rst_o(core_rst_o),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen on the memory side
    always @(negedge clk) begin
        if (we_o) obs_q.push_back({17'd0, tgt_o, addr_o, wdata_o});
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit clr);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        err_clr = clr;
        @(negedge clk);
        rx_dv   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_err = 3'b000;
    endtask

    // Build a WRITE frame and record the writes it should produce
    task automatic buildWrite(input int tgt, input int len, input int addr, input bit badCsum);
        logic [7:0]  sum;
        logic [7:0]  cs;
        logic [31:0] d;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(tgt << 4));
        frame_q.push_back(8'(len));
        frame_q.push_back(8'(addr));
        frame_q.push_back(8'(addr >> 8));
        for (int w = 0; w <= len; w++) begin
            d = $urandom;
            for (int k = 0; k < 4; k++) frame_q.push_back(8'(d >> (8 * k)));
            if (tgt < NUM_TGT)
                exp_q.push_back({17'd0, 1'(tgt), 14'((addr + w) % 16384), d});
        end
        sum = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) sum = sum + frame_q[i];
        cs = 8'h00 - sum;
        if (badCsum) cs = cs ^ 8'h3C;
        frame_q.push_back(cs);
        if (tgt >= NUM_TGT) model_err[2] = 1'b1;
        if (badCsum) model_err[0] = 1'b1;
    endtask

    // Build a RUN (op 1) or HALT (op 2) frame and update the model
    task automatic buildCtrl(input int op, input bit badCsum);
        logic [7:0] cs;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(op));
        cs = 8'h00 - 8'(op);
        if (badCsum) cs = cs ^ 8'h3C;
        frame_q.push_back(cs);
        if (badCsum) model_err[0] = 1'b1;
        else model_core_rst = (op == 2);
    endtask

    task automatic applyStimulus(input int maxGap);
        for (int i = 0; i < frame_q.size(); i++) begin
            sendByte(frame_q[i], 1'b0);
            idle($urandom_range(0, maxGap));
        end
    endtask

    task automatic checkFrameResult(input string tag);
        int n;
        idle(3);
        checkOutput({tag, ".busy"}, 64'(busy_o), 64'(0));
        checkOutput({tag, ".err"}, 64'(err_o), 64'(model_err));
        checkOutput({tag, ".core_rst"}, 64'(core_rst_o), 64'(model_core_rst));
        checkOutput({tag, ".nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s.wr%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        int tgt;
        rst = 1'b1;
        rx_dv = 1'b0;
        rx_byte = 8'h00;
        err_clr = 1'b0;
        model_core_rst = 1'b1;
        model_err = 3'b000;

        // Reset values
        idle(3);
        checkOutput("rst.we", 64'(we_o), 64'(0));
        checkOutput("rst.tgt", 64'(tgt_o), 64'(0));
        checkOutput("rst.addr", 64'(addr_o), 64'(0));
        checkOutput("rst.wdata", 64'(wdata_o), 64'(0));
        checkOutput("rst.core_rst", 64'(core_rst_o), 64'(1));
        checkOutput("rst.busy", 64'(busy_o), 64'(0));
        checkOutput("rst.err", 64'(err_o), 64'(0));
        rst = 1'b0;
        idle(2);

        // Single word write with exact strobe timing
        sendByte(8'hA5, 1'b0);
        checkOutput("w1.busy", 64'(busy_o), 64'(1));
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h10, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h78, 1'b0); idle(1);
        sendByte(8'h56, 1'b0); idle(1);
        sendByte(8'h34, 1'b0); idle(1);
        sendByte(8'h12, 1'b0);
        checkOutput("w1.we", 64'(we_o), 64'(1));
        checkOutput("w1.tgt", 64'(tgt_o), 64'(0));
        checkOutput("w1.addr", 64'(addr_o), 64'h0010);
        checkOutput("w1.wdata", 64'(wdata_o), 64'h12345678);
        @(negedge clk);
        checkOutput("w1.we_pulse", 64'(we_o), 64'(0));
        sendByte(8'hDC, 1'b0);
        exp_q.push_back({17'd0, 1'b0, 14'h0010, 32'h12345678});
        checkFrameResult("w1");

        // Address wrap on target 1, then a maximum-length frame
        buildWrite(1, 1, 16'h3FFF, 1'b0);
        applyStimulus(3);
        checkFrameResult("wrap");
        buildWrite(0, 255, 16'hFF80, 1'b0);
        applyStimulus(1);
        checkFrameResult("len255");

        // RUN releases the core the cycle after the checksum byte
        sendByte(8'hA5, 1'b0); idle(2);
        sendByte(8'h01, 1'b0); idle(2);
        checkOutput("run.before", 64'(core_rst_o), 64'(1));
        sendByte(8'hFF, 1'b0);
        checkOutput("run.after", 64'(core_rst_o), 64'(0));
        model_core_rst = 1'b0;
        checkFrameResult("run");
        buildCtrl(2, 1'b0);
        applyStimulus(2);
        checkFrameResult("halt");

        // Bad checksum on RUN leaves the core held, then clear the flag
        buildCtrl(1, 1'b1);
        applyStimulus(2);
        checkFrameResult("run_badcs");
        pulseClear();
        idle(1);
        checkOutput("clr.err", 64'(err_o), 64'(0));

        // Out-of-range target suppresses writes
        buildWrite(3, 1, 16'h0100, 1'b0);
        applyStimulus(2);
        checkFrameResult("badtgt");

        // Clear and a new checksum error in the same cycle
        buildCtrl(1, 1'b1);
        sendByte(frame_q[0], 1'b0); idle(2);
        sendByte(frame_q[1], 1'b0); idle(2);
        sendByte(frame_q[2], 1'b1);
        model_err = 3'b001;
        checkFrameResult("clr_same");
        pulseClear();

        // Timeout in the middle of a word discards the partial word
        sendByte(8'hA5, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h20, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h11, 1'b0); idle(1);
        sendByte(8'h22, 1'b0);
        idle(TIMEOUT - 6);
        checkOutput("tmo.busy_before", 64'(busy_o), 64'(1));
        idle(10);
        model_err[1] = 1'b1;
        checkFrameResult("tmo");
        buildWrite(0, 0, 16'h0020, 1'b0);
        applyStimulus(2);
        checkFrameResult("after_tmo");

        // Reset in the middle of a frame
        buildCtrl(1, 1'b0);
        applyStimulus(2);
        checkFrameResult("run2");
        sendByte(8'hA5, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'h10, 1'b0); idle(1);
        sendByte(8'h00, 1'b0); idle(1);
        sendByte(8'hAA, 1'b0); idle(1);
        sendByte(8'hBB, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_core_rst = 1'b1;
        model_err = 3'b000;
        checkFrameResult("midrst");
        buildWrite(0, 2, int'($urandom_range(0, 65535)), 1'b0);
        applyStimulus(2);
        checkFrameResult("after_rst");

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h00;
                    sendByte(b, 1'b0);
                    idle($urandom_range(0, 3));
                end
            end
            if ($urandom_range(0, 1) == 1) pulseClear();
            kind = int'($urandom_range(0, 4));
            if (kind <= 2) begin
                tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
                buildWrite(tgt, int'($urandom_range(0, 5)), int'($urandom_range(0, 65535)),
                           $urandom_range(0, 5) == 0);
            end else begin
                buildCtrl(kind - 2, $urandom_range(0, 5) == 0);
            end
            applyStimulus(4);
            checkFrameResult($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
